// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Latches the winner's byte, pulses start, tracks busy and reports done/err to the owner.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           done,
    output logic                         err,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active,
    output logic                         uart_start,
    output logic [DATA_W-1:0]            uart_data,
    input  logic                         uart_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StWaitHi, StWaitLo} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d, done_q, done_d;
    logic                err_q, err_d, start_q, start_d, active_q, active_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [DATA_W-1:0]   win_data;
    logic [IDX_W:0]      idx_ext;
    logic [IDX_W-1:0]    next_ptr;

    // First requester at or above the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        idx_ext   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (idx_ext >= (IDX_W+1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && req[idx_ext[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_ext[IDX_W-1:0];
                win_data  = req_data[int'(idx_ext)*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        active_d = active_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found && !uart_busy) begin
                    ack_d[win_idx] = 1'b1;
                    grant_d        = win_idx;
                    data_d         = win_data;
                    active_d       = 1'b1;
                    state_d        = StStart;
                end
            end
            StStart: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (uart_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    rr_d     = next_ptr;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitLo: begin
                if (!uart_busy) begin
                    done_d[grant_q] = 1'b1;
                    active_d        = 1'b0;
                    rr_d            = next_ptr;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            active_q <= active_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign err        = err_q;
    assign grant_id   = grant_q;
    assign active     = active_q;
    assign uart_start = start_q;
    assign uart_data  = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed requests push expected completions,
// a negedge monitor pops and compares on every done/err pulse.
module tb_uart_tx_sched;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 8;
    localparam int FRAME        = 20;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        ack, done;
    logic                      err, active, uart_start, uart_busy;
    logic [1:0]                grant_id;
    logic [DATA_W-1:0]         uart_data;

    uart_tx_sched #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .done(done),
        .err(err), .grant_id(grant_id), .active(active), .uart_start(uart_start),
        .uart_data(uart_data), .uart_busy(uart_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Transmitter model: busy rises the cycle after start and lasts FRAME cycles.
    logic       dead = 1'b0;
    logic       force_busy = 1'b0;
    int         frame_cnt = 0;
    logic [7:0] cap_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_start && !dead) begin
            cap_data  <= uart_data;
            frame_cnt <= FRAME;
        end else if (frame_cnt > 0) begin
            frame_cnt <= frame_cnt - 1;
        end
    end
    assign uart_busy = force_busy | (frame_cnt != 0);

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset && (done != '0 || err)) begin
            check("single_event", $countones({done, err}), 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: done=%b err=%b expected nothing", done, err);
            end else begin
                e = exp_q.pop_front();
                check("event_is_err", {31'b0, err}, {31'b0, e.is_err});
                check("done_vec", {28'b0, done}, e.is_err ? 32'h0 : (32'h1 << e.id));
                check("event_grant_id", {30'b0, grant_id}, {30'b0, e.id});
                check("event_uart_data", {24'b0, uart_data}, {24'b0, e.data});
                if (!e.is_err) check("rx_byte", {24'b0, cap_data}, {24'b0, e.data});
            end
        end
    end

    task automatic push(input logic is_err, input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e = '{is_err: is_err, id: id, data: data};
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ack"}, {28'b0, ack}, 0);
        check({tag, "_done"}, {28'b0, done}, 0);
        check({tag, "_err"}, {31'b0, err}, 0);
        check({tag, "_start"}, {31'b0, uart_start}, 0);
        check({tag, "_active"}, {31'b0, active}, 0);
        check({tag, "_data"}, {24'b0, uart_data}, 0);
        check({tag, "_grant"}, {30'b0, grant_id}, 0);
    endtask

    task automatic drop_on_ack();
        int n = 0;
        while (req != '0 && n < 400) begin
            @(negedge clk);
            req = req & ~ack;
            n++;
        end
        check("all_acked", {28'b0, req}, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || active) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drained", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int acks;
        int n;
        int t0;
        int early;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single request: ack next cycle, start one cycle after ack
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        push(1'b0, 2'd1, 8'hA5);
        @(negedge clk);
        check("single_ack", {28'b0, ack}, 32'b0010);
        check("single_active", {31'b0, active}, 1);
        check("single_grant", {30'b0, grant_id}, 1);
        check("single_nostart", {31'b0, uart_start}, 0);
        req = '0;
        @(negedge clk);
        check("single_ack_pulse", {28'b0, ack}, 0);
        check("single_start", {31'b0, uart_start}, 1);
        check("single_data", {24'b0, uart_data}, 32'hA5);
        @(negedge clk);
        check("single_start_pulse", {31'b0, uart_start}, 0);
        wait_drain();

        // All four from reset: order 0,1,2,3
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        req_data = 32'h4433_2211;
        push(1'b0, 2'd0, 8'h11);
        push(1'b0, 2'd1, 8'h22);
        push(1'b0, 2'd2, 8'h33);
        push(1'b0, 2'd3, 8'h44);
        req = 4'hF;
        drop_on_ack();
        wait_drain();

        // Fairness: 0 and 2 held high alternate
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 2'd0, 8'h11);
            push(1'b0, 2'd2, 8'h33);
        end
        req = 4'b0101;
        acks = 0;
        n = 0;
        while (acks < 6 && n < 1000) begin
            @(negedge clk);
            if (ack != '0) acks++;
            n++;
        end
        req = '0;
        check("fair_acks", acks, 6);
        wait_drain();

        // Pointer now at 3: 3 wins first, then wraps to 0
        req_data[31:24] = 8'hD3;
        req_data[7:0] = 8'hD0;
        push(1'b0, 2'd3, 8'hD3);
        push(1'b0, 2'd0, 8'hD0);
        req = 4'b1001;
        drop_on_ack();
        wait_drain();

        // Timeout: busy never rises
        dead = 1'b1;
        req_data[7:0] = 8'h5A;
        push(1'b1, 2'd0, 8'h5A);
        req = 4'b0001;
        n = 0;
        while (!uart_start && n < 20) begin
            @(negedge clk);
            req = req & ~ack;
            n++;
        end
        check("to_start_seen", {31'b0, uart_start}, 1);
        t0 = cyc;
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_err_seen", {31'b0, err}, 1);
        check("to_latency", cyc - t0, BUSY_TIMEOUT);
        check("to_active_low", {31'b0, active}, 0);
        dead = 1'b0;
        wait_drain();
        req_data[23:16] = 8'h77;
        push(1'b0, 2'd2, 8'h77);
        req = 4'b0100;
        drop_on_ack();
        wait_drain();

        // Reset mid-frame while transmitter busy
        req_data[7:0] = 8'hC3;
        req = 4'b0001;
        drop_on_ack();
        n = 0;
        while (!uart_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_busy_seen", {31'b0, uart_busy}, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        check("mid_busy_still", {31'b0, uart_busy}, 1);
        req_data[15:8] = 8'h99;
        push(1'b0, 2'd1, 8'h99);
        req = 4'b0010;
        early = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (ack != '0) early++;
            n++;
        end while (uart_busy && n < 100);
        check("post_reset_no_ack", early, 0);
        @(negedge clk);
        check("post_reset_ack", {28'b0, ack}, 32'b0010);
        req = '0;
        wait_drain();

        // Busy held in IDLE blocks grant
        force_busy = 1'b1;
        req_data[7:0] = 8'h42;
        push(1'b0, 2'd0, 8'h42);
        req = 4'b0001;
        early = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack != '0) early++;
        end
        check("busy_idle_no_ack", early, 0);
        force_busy = 1'b0;
        @(negedge clk);
        check("busy_idle_ack", {28'b0, ack}, 32'b0001);
        req = '0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
